// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU inter-stage register bank.
// Holds the occupancy width derivation and the payload field offsets.
package cpu_pipe_pkg;

  // Each stage holds two entries, so the count must reach 2*DEPTH without wrapping.
  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  localparam int OPC_LSB     = 12;
  localparam int OPC_W       = 4;
  localparam int DST_LSB     = 9;
  localparam int DST_W       = 3;
  localparam int ALU_LSB     = 2;
  localparam int ALU_W       = 7;
  localparam int MEM2REG_BIT = 1;
  localparam int REGWE_BIT   = 0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic pipeline stage: a main and a skid register.
// The upstream ready depends only on the skid valid bit, so it is a register output.
module pipe_skid_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_up_ready,
  output logic             o_dn_valid,
  input  logic             i_dn_ready,
  output logic [WIDTH-1:0] o_dn_data,
  output logic             o_main_v,
  output logic             o_skid_v
);

  logic             r_main_v, r_skid_v;
  logic [WIDTH-1:0] r_main_d, r_skid_d;
  logic             w_acc, w_drain;

  assign w_acc      = i_up_valid & ~r_skid_v;
  assign w_drain    = r_main_v & i_dn_ready;
  assign o_up_ready = ~r_skid_v;
  assign o_dn_valid = r_main_v;
  assign o_dn_data  = r_main_d;
  assign o_main_v   = r_main_v;
  assign o_skid_v   = r_skid_v;

  // The skid is only ever filled while main is full, so a skid beat implies a main beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (i_flush) begin
      // A beat draining this edge was already taken downstream; everything else dies.
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_drain && r_skid_v) begin
      r_main_d <= r_skid_d;
      r_skid_v <= 1'b0;
    end else if (w_acc && (!r_main_v || w_drain)) begin
      r_main_v <= 1'b1;
      r_main_d <= i_up_data;
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
      r_skid_d <= i_up_data;
    end else if (w_drain) begin
      r_main_v <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_bank.sv
// Elastic chain of DEPTH skid slots replacing the CPU inter-stage registers.
// Ready travels backwards one slot per cycle; there is no combinational out_ready->in_ready path.
module pipe_stage_bank
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DEPTH-1:0] flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH:0]            w_vld, w_rdy;
  logic [DEPTH:0][WIDTH-1:0] w_dat;
  logic [DEPTH-1:0]          w_main_v, w_skid_v;
  logic [CNT_W-1:0]          w_occ;

  assign w_vld[0]     = in_valid;
  assign w_dat[0]     = in_data;
  assign in_ready     = w_rdy[0];
  assign w_rdy[DEPTH] = out_ready;
  assign out_valid    = w_vld[DEPTH];
  assign out_data     = w_dat[DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pipe_skid_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flush[g]),
      .i_up_valid (w_vld[g]),
      .i_up_data  (w_dat[g]),
      .o_up_ready (w_rdy[g]),
      .o_dn_valid (w_vld[g+1]),
      .i_dn_ready (w_rdy[g+1]),
      .o_dn_data  (w_dat[g+1]),
      .o_main_v   (w_main_v[g]),
      .o_skid_v   (w_skid_v[g])
    );
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++)
      w_occ = w_occ + CNT_W'(w_main_v[i]) + CNT_W'(w_skid_v[i]);
  end

  assign occupancy = w_occ;

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Bench for pipe_stage_bank: a per-stage queue model checked every cycle,
// directed scenarios with literal expectations, then randomised traffic on two configurations.
module tb_pipe_stage_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or;
  logic [15:0] a_id, a_od;
  logic [3:0]  a_fl, a_occ;
  logic        b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_id, b_od;
  logic [0:0]  b_fl;
  logic [1:0]  b_occ;

  pipe_stage_bank #(.WIDTH(16), .DEPTH(4), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .flush(a_fl),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occupancy(a_occ));

  pipe_stage_bank #(.WIDTH(32), .DEPTH(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .flush(b_fl),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occupancy(b_occ));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: each stage is a FIFO of at most two beats, oldest first.
  int          mn [2][4];
  logic [31:0] md [2][4][2];

  task automatic mstep(input int i, input int D, input logic iv, input logic [31:0] id,
                       input logic orr, input logic [3:0] fl);
    int          n0 [4];
    logic [31:0] fr [4];
    logic        t  [5];
    for (int k = 0; k < D; k++) begin n0[k] = mn[i][k]; fr[k] = md[i][k][0]; end
    for (int k = 0; k <= D; k++) begin
      logic sv, dr;
      if (k == 0) sv = iv; else sv = (n0[k-1] > 0);
      if (k == D) dr = orr; else dr = (n0[k] < 2);
      t[k] = sv && dr;
    end
    for (int k = 0; k < D; k++)
      if (t[k+1]) begin md[i][k][0] = md[i][k][1]; mn[i][k]--; end
    for (int k = 0; k < D; k++)
      if (t[k]) begin
        md[i][k][mn[i][k]] = (k == 0) ? id : fr[k-1];
        mn[i][k]++;
      end
    for (int k = 0; k < D; k++)
      if (fl[k]) mn[i][k] = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) mn[i][k] = 0;
    end else begin
      mstep(0, 4, a_iv, {16'h0, a_id}, a_or, a_fl);
      mstep(1, 1, b_iv, b_id, b_or, {3'b000, b_fl});
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          acc_cnt, first_in;
  logic [15:0] outq [$];
  int          oute [$];

  task automatic clear_log;
    acc_cnt = 0; first_in = -1; outq.delete(); oute.delete();
  endtask

  // Compare DUT against the model and log handshakes, away from the active edge.
  always @(negedge clk) begin
    int occ;
    chk("a_out_valid", a_ov, mn[0][3] > 0);
    if (mn[0][3] > 0) chk("a_out_data", a_od, md[0][3][0]);
    chk("a_in_ready", a_ir, mn[0][0] < 2);
    occ = mn[0][0] + mn[0][1] + mn[0][2] + mn[0][3];
    chk("a_occupancy", a_occ, occ);
    chk("b_out_valid", b_ov, mn[1][0] > 0);
    if (mn[1][0] > 0) chk("b_out_data", b_od, md[1][0][0]);
    chk("b_in_ready", b_ir, mn[1][0] < 2);
    chk("b_occupancy", b_occ, mn[1][0]);
    if (!rst) begin
      if (a_iv && a_ir) begin acc_cnt++; if (first_in < 0) first_in = cyc + 1; end
      if (a_ov && a_or) begin outq.push_back(a_od); oute.push_back(cyc + 1); end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick;
  endtask

  task automatic push(input logic [15:0] v);
    int b = 0;
    a_iv = 1'b1; a_id = v;
    while (!a_ir && b < 50) begin tick; b++; end
    if (b >= 50) chk("push_timeout", 32'(b), 0);
    tick;
    a_iv = 1'b0;
  endtask

  initial begin
    logic acc;
    rst = 1'b1;
    a_iv = 0; a_id = 0; a_fl = 0; a_or = 0;
    b_iv = 0; b_id = 0; b_fl = 0; b_or = 0;
    clear_log;
    idle(2);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_in_ready", a_ir, 1);
    chk("rst_out_data", a_od, 0);
    rst = 1'b0;

    // Free-flowing stream
    a_or = 1; clear_log;
    for (int v = 1; v <= 16; v++) push(16'(v));
    idle(10);
    chk("t1_count", outq.size(), 16);
    for (int i = 0; i < outq.size() && i < 16; i++) chk("t1_data", outq[i], i + 1);
    if (oute.size() == 16) begin
      chk("t1_latency", oute[0] - first_in, 4);
      chk("t1_no_bubble", oute[15] - oute[0], 15);
    end

    // Backpressure fills exactly 2*DEPTH entries
    a_or = 0; clear_log; a_id = 16'h0001; a_iv = 1;
    repeat (20) begin acc = a_iv && a_ir; tick; if (acc) a_id++; end
    a_iv = 0;
    chk("t2_accepted", acc_cnt, 8);
    chk("t2_in_ready", a_ir, 0);
    chk("t2_occ_full", a_occ, 8);
    a_or = 1; idle(20);
    chk("t2_count", outq.size(), 8);
    for (int i = 0; i < outq.size() && i < 8; i++) chk("t2_data", outq[i], i + 1);
    chk("t2_occ_empty", a_occ, 0);

    // Flush front half of a full pipe
    a_or = 0; clear_log;
    for (int v = 'h31; v <= 'h38; v++) push(16'(v));
    idle(3);
    chk("t3_occ_full", a_occ, 8);
    a_fl = 4'b0011; tick; a_fl = 0;
    chk("t3_occ_after", a_occ, 4);
    a_or = 1; idle(10);
    chk("t3_count", outq.size(), 4);
    for (int i = 0; i < outq.size() && i < 4; i++) chk("t3_data", outq[i], 'h31 + i);

    // Beat entering a flushed stage is lost
    clear_log;
    a_iv = 1; a_id = 16'h0077; a_fl = 4'b0001; tick;
    a_iv = 0; a_fl = 0; idle(8);
    chk("t3b_count", outq.size(), 0);
    chk("t3b_occ", a_occ, 0);

    // Flush on the last stage while draining
    a_or = 0; clear_log;
    push(16'hBEEF); push(16'hCAFE); idle(8);
    chk("t4_out_valid", a_ov, 1);
    chk("t4_out_data", a_od, 16'hBEEF);
    chk("t4_occ", a_occ, 2);
    a_or = 1; a_fl = 4'b1000; tick; a_fl = 0; idle(5);
    chk("t4_count", outq.size(), 1);
    if (outq.size() > 0) chk("t4_data", outq[0], 16'hBEEF);
    chk("t4_occ_after", a_occ, 0);

    // Reset mid-stream
    a_or = 0; clear_log;
    for (int v = 'h51; v <= 'h55; v++) push(16'(v));
    idle(6);
    chk("t5_occ", a_occ, 5);
    #2 rst = 1'b1;
    #1;
    chk("t5_out_valid", a_ov, 0);
    chk("t5_occ_rst", a_occ, 0);
    chk("t5_in_ready", a_ir, 1);
    tick; rst = 1'b0; a_or = 1; clear_log;
    idle(10);
    chk("t5_no_stale", outq.size(), 0);

    // Randomised traffic on both configurations
    for (int c = 0; c < 3000; c++) begin
      int pr;
      pr = (c / 300) % 4 == 1 ? 2 : ((c / 300) % 4 == 3 ? 5 : 9);
      a_iv = $urandom_range(0, 9) < 7;
      a_id = 16'($urandom);
      a_or = $urandom_range(0, 9) < pr;
      for (int k = 0; k < 4; k++) a_fl[k] = ($urandom_range(0, 24) == 0);
      b_iv = $urandom_range(0, 9) < 6;
      b_id = $urandom;
      b_or = $urandom_range(0, 9) < pr;
      b_fl[0] = ($urandom_range(0, 24) == 0);
      tick;
    end
    a_iv = 0; a_fl = 0; b_iv = 0; b_fl = 0; a_or = 1; b_or = 1;
    idle(10);
    chk("t6_a_drained", a_occ, 0);
    chk("t6_b_drained", b_occ, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
